sram_wbuf_seq: RTL and testbench
================================

// Module: sram_wbuf_seq
// PURPOSE
//  Parametrised weight-buffer SRAM with a burst load sequencer and a tagged read pipeline.
//  - Load: an external loader streams DEPTH-bounded bursts into the array through a
//    start/len command and a valid/ready data stream.
//  - Read: compute datapaths issue valid/ready read requests and receive responses with
//    rd_valid, after a fixed, parametrised latency.
//  - Replaces the fixed 128x128 projection-weight wrapper. Adds width/depth generality,
//    per-lane write mask, load handshake and response valid tracking.
// PARAMETERS
//  DATA_W    128               word width in bits; must be a multiple of LANE_W
//  DEPTH     128               number of words; need not be a power of 2
//  ADDR_W    $clog2(DEPTH)     address width
//  LANE_W    32                write-mask granularity in bits
//  READ_LAT  2                 extra output register stages after the 1-cycle array read, >=0
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          synchronous active-low reset
//  ld_start     in   1          load-burst command pulse; sampled only in IDLE
//  ld_base      in   ADDR_W     first address of the burst
//  ld_len       in   ADDR_W+1   beats in the burst, 1..DEPTH; 0 = ignored
//  ld_valid     in   1          load data beat valid
//  ld_ready     out  1          load data beat accepted when ld_valid & ld_ready
//  ld_data      in   DATA_W     load data
//  ld_mask      in   DATA_W/LANE_W  per-lane write enable, 1 = write lane
//  ld_busy      out  1          high while in LOAD
//  ld_done      out  1          1-cycle pulse after the last beat is written
//  rd_req       in   1          read request valid
//  rd_ready     out  1          read request accepted when rd_req & rd_ready
//  rd_addr      in   ADDR_W     read address; must be < DEPTH
//  rd_valid     out  1          response valid; no backpressure
//  rd_data      out  DATA_W     response data
// BEHAVIOUR
//  Reset (sync, rst_n=0 at posedge)
//   - FSM -> IDLE. ld_ready=0, ld_busy=0, ld_done=0, rd_valid=0, rd_data=0.
//   - All pipeline stages clear, both valid and data.
//   - Array contents retained, not cleared.
//   - Reset mid-burst aborts the burst: no ld_done; beats already written stay written.
//   - All in-flight read responses are dropped.
//  FSM states: IDLE, LOAD
//   - IDLE: ld_ready=0, rd_ready=1.
//     ld_start with ld_len!=0 -> LOAD; wr_ptr<=ld_base, beats_left<=ld_len.
//     ld_start with ld_len==0 -> stay in IDLE, no pulse.
//   - LOAD: ld_ready=1, rd_ready=0, ld_busy=1. ld_start is ignored.
//     Each accepted beat writes ld_data into mem[wr_ptr], only in lanes with ld_mask=1.
//     wr_ptr<=(wr_ptr==DEPTH-1)?0:wr_ptr+1, so the burst wraps past the top of the array.
//     beats_left decrements on each accepted beat.
//     The beat that brings beats_left to 0 -> IDLE. ld_done=1 on the following cycle.
//  Reads
//   - rd_ready is combinational from FSM state only; it does not depend on rd_req.
//   - The array is read in the accept cycle. Data is available 1 cycle later.
//   - Both data and valid then pass through READ_LAT register stages.
//   - rd_valid/rd_data appear exactly 1+READ_LAT cycles after the accept edge.
//     With the default, a request accepted at cycle t responds at t+3.
//   - Back-to-back accepted requests give back-to-back responses in order, 1 per cycle.
//   - READ_LAT=0: rd_data is driven directly by the array output register.
//   - rd_data holds its last value when rd_valid=0. Stages shift every cycle.
//  Loads and reads
//   - Reads accepted in the cycle before entering LOAD complete normally. Their data is
//     pre-load data, because the array read happens before any LOAD write.
//   - Only one access per cycle: LOAD gates reads, so write and read never collide.
//   - The array is a single-port behavioural model, synchronous write and synchronous read.
//   - Address rd_addr>=DEPTH is illegal; an assertion fires in simulation.
// TESTING
//  1 Reset then idle: rst_n=0 for 2 cycles -> all outputs 0; rd_ready=1, ld_ready=0.
//  2 Burst: ld_start, base=5, len=3, full mask, data A/B/C with ld_valid gaps
//    -> mem[5..7]=A,B,C; ld_done pulses once 1 cycle after C; rd_ready low throughout.
//  3 Wrap and mask: DEPTH=128, base=126, len=4 -> writes 126,127,0,1.
//    Mask 4'b0101 on beat 0 -> only lanes 0 and 2 change at addr 126.
//  4 Read pipeline: rd_req on 4 consecutive cycles, addr 0..3 -> rd_valid high on
//    4 consecutive cycles, starting at accept+3, with the data in order.
//  5 Load/read interleave: rd accepted, then ld_start next cycle rewriting the same addr
//    -> response returns old data; a new rd_req during LOAD sees rd_ready=0.
//  6 Reset mid-burst: rst_n low after 2 of 5 beats -> no ld_done, IDLE, first 2 beats
//    persist. Repeat tests 4 and 5 at READ_LAT=0 -> response at accept+1.

Source files
------------

// File: rtl/sram_wbuf_seq.sv
// Weight-buffer SRAM: burst load sequencer (IDLE/LOAD) in front of a single-port array,
// with a valid-tracked read pipeline of 1+READ_LAT cycles.
module sram_wbuf_seq #(
  parameter int DATA_W   = 128,
  parameter int DEPTH    = 128,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int LANE_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ld_start,
  input  logic [ADDR_W-1:0]        i_ld_base,
  input  logic [ADDR_W:0]          i_ld_len,
  input  logic                     i_ld_valid,
  output logic                     o_ld_ready,
  input  logic [DATA_W-1:0]        i_ld_data,
  input  logic [DATA_W/LANE_W-1:0] i_ld_mask,
  output logic                     o_ld_busy,
  output logic                     o_ld_done,
  input  logic                     i_rd_req,
  output logic                     o_rd_ready,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  output logic                     o_rd_valid,
  output logic [DATA_W-1:0]        o_rd_data
);
  localparam int LANES = DATA_W / LANE_W;

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  state_t              r_state, w_state_nx;
  logic [ADDR_W-1:0]   r_wr_ptr, w_wr_ptr_nx;
  logic [ADDR_W:0]     r_left, w_left_nx;
  logic                r_ld_done, w_done_nx;
  logic                w_wr_en;
  logic                w_rd_acc;
  logic [DATA_W-1:0]   w_bmask;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  always_comb begin
    w_state_nx  = r_state;
    w_wr_ptr_nx = r_wr_ptr;
    w_left_nx   = r_left;
    w_done_nx   = 1'b0;
    w_wr_en     = 1'b0;
    o_ld_ready  = 1'b0;
    o_ld_busy   = 1'b0;
    o_rd_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_rd_ready = 1'b1;
        if (i_ld_start && (i_ld_len != '0)) begin
          w_state_nx  = S_LOAD;
          w_wr_ptr_nx = i_ld_base;
          w_left_nx   = i_ld_len;
        end
      end
      S_LOAD: begin
        o_ld_ready = 1'b1;
        o_ld_busy  = 1'b1;
        if (i_ld_valid) begin
          w_wr_en     = i_rst_n;
          w_wr_ptr_nx = (r_wr_ptr == ADDR_W'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
          w_left_nx   = r_left - 1'b1;
          if (r_left == (ADDR_W+1)'(1)) begin
            w_state_nx = S_IDLE;
            w_done_nx  = 1'b1;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_left    <= '0;
      r_ld_done <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_wr_ptr  <= w_wr_ptr_nx;
      r_left    <= w_left_nx;
      r_ld_done <= w_done_nx;
    end
  end

  assign o_ld_done = r_ld_done;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_bmask[l*LANE_W +: LANE_W] = {LANE_W{i_ld_mask[l]}};
  end

  // Array has no reset: contents survive rst_n, only the sequencer and pipeline clear.
  always_ff @(posedge i_clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr] <= (r_mem[r_wr_ptr] & ~w_bmask) | (i_ld_data & w_bmask);
  end

  assign w_rd_acc = i_rd_req & o_rd_ready;

  logic [READ_LAT:0]             w_vld;
  logic [READ_LAT:0][DATA_W-1:0] w_dat;
  logic                          r_vld0;
  logic [DATA_W-1:0]             r_dat0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld0 <= 1'b0;
      r_dat0 <= '0;
    end else begin
      r_vld0 <= w_rd_acc;
      if (w_rd_acc) r_dat0 <= r_mem[i_rd_addr];
    end
  end

  assign w_vld[0] = r_vld0;
  assign w_dat[0] = r_dat0;

  // Each stage only captures data alongside a valid, so rd_data holds between responses.
  for (genvar s = 1; s <= READ_LAT; s++) begin : g_stg
    logic              r_v;
    logic [DATA_W-1:0] r_d;
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else begin
        r_v <= w_vld[s-1];
        if (w_vld[s-1]) r_d <= w_dat[s-1];
      end
    end
    assign w_vld[s] = r_v;
    assign w_dat[s] = r_d;
  end

  assign o_rd_valid = w_vld[READ_LAT];
  assign o_rd_data  = w_dat[READ_LAT];

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_rd_acc)
      assert ({1'b0, i_rd_addr} < (ADDR_W+1)'(DEPTH))
        else $error("sram_wbuf_seq: rd_addr %0d out of range", i_rd_addr);
  end
`endif
endmodule

// File: tb/tb_sram_wbuf_seq.sv
// Directed bench: table of per-cycle vectors for the basic burst/read flow plus
// hand-written sequences for wrap/mask, read pipelining, load/read interleave, reset mid-burst.
module tb_sram_wbuf_seq;
  logic         clk = 1'b0;
  logic         rst_n, st, lv, rq;
  logic [6:0]   base, ra;
  logic [7:0]   len;
  logic [127:0] dat;
  logic [3:0]   msk;
  logic         lr, busy, done, rr, v2;
  logic [127:0] d2;
  logic         lr0, busy0, done0, rr0, v0;
  logic [127:0] d0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_wbuf_seq #(.DATA_W(128), .DEPTH(128), .LANE_W(32), .READ_LAT(2)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ld_start(st), .i_ld_base(base), .i_ld_len(len),
    .i_ld_valid(lv), .o_ld_ready(lr), .i_ld_data(dat), .i_ld_mask(msk), .o_ld_busy(busy),
    .o_ld_done(done), .i_rd_req(rq), .o_rd_ready(rr), .i_rd_addr(ra), .o_rd_valid(v2),
    .o_rd_data(d2));

  sram_wbuf_seq #(.DATA_W(128), .DEPTH(128), .LANE_W(32), .READ_LAT(0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ld_start(st), .i_ld_base(base), .i_ld_len(len),
    .i_ld_valid(lv), .o_ld_ready(lr0), .i_ld_data(dat), .i_ld_mask(msk), .o_ld_busy(busy0),
    .o_ld_done(done0), .i_rd_req(rq), .o_rd_ready(rr0), .i_rd_addr(ra), .o_rd_valid(v0),
    .o_rd_data(d0));

  typedef struct {
    logic         st;
    logic [6:0]   base;
    logic [7:0]   len;
    logic         lv;
    logic [127:0] dat;
    logic         rq;
    logic [6:0]   ra;
    logic [5:0]   ef;   // {ld_ready, ld_busy, ld_done, rd_ready, rd_valid(lat2), rd_valid(lat0)}
    logic [127:0] ed2;
    logic [127:0] ed0;
  } vec_t;

  vec_t         tv[14];
  logic [127:0] bd[8];
  logic [3:0]   bm[8];
  logic [127:0] exp4[4];

  function automatic logic [127:0] mkw(input logic [7:0] b);
    return {{4{b + 8'd3}}, {4{b + 8'd2}}, {4{b + 8'd1}}, {4{b}}};
  endfunction

  function automatic vec_t mkv(input logic s, input logic [6:0] b, input logic [7:0] n,
                               input logic v, input logic [127:0] d, input logic q,
                               input logic [6:0] a, input logic [5:0] ef,
                               input logic [127:0] e2, input logic [127:0] e0);
    vec_t t;
    t.st = s; t.base = b; t.len = n; t.lv = v; t.dat = d; t.rq = q; t.ra = a;
    t.ef = ef; t.ed2 = e2; t.ed0 = e0;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    st = 0; base = '0; len = '0; lv = 0; dat = '0; msk = 4'hF; rq = 0; ra = '0;
  endtask

  task automatic burst(input logic [6:0] b, input logic [7:0] n);
    st = 1; base = b; len = n;
    @(negedge clk); step();
    st = 0;
    for (int i = 0; i < int'(n); i++) begin
      lv = 1; dat = bd[i]; msk = bm[i];
      @(negedge clk);
      chk("burst_busy", {busy, rr}, 2'b10);
      step();
    end
    lv = 0; msk = 4'hF;
    @(negedge clk);
    chk("burst_done", {done, busy}, 2'b10);
    step();
    @(negedge clk);
    chk("burst_done_once", done, 1'b0);
    step();
  endtask

  task automatic rd_chk(input string nm, input logic [6:0] a, input logic [127:0] exp);
    rq = 1; ra = a;
    @(negedge clk); step();
    rq = 0;
    step(); step();
    @(negedge clk);
    chk({nm, "_v"}, v2, 1'b1);
    chk(nm, d2, exp);
    step();
  endtask

  initial begin
    logic [127:0] A, B, C, Z;
    A = mkw(8'hA0); B = mkw(8'hB0); C = mkw(8'hC0); Z = mkw(8'hE0);

    //                st  base len  lv dat rq  ra  ef        ed2 ed0
    tv[0]  = mkv(1, 7'd5, 8'd3, 0, '0, 0, 7'd0, 6'b000100, '0, '0);
    tv[1]  = mkv(0, 7'd0, 8'd0, 0, '0, 0, 7'd0, 6'b110000, '0, '0);
    tv[2]  = mkv(0, 7'd0, 8'd0, 1, A,  0, 7'd0, 6'b110000, '0, '0);
    tv[3]  = mkv(1, 7'd0, 8'd5, 0, '0, 0, 7'd0, 6'b110000, '0, '0);
    tv[4]  = mkv(0, 7'd0, 8'd0, 1, B,  0, 7'd0, 6'b110000, '0, '0);
    tv[5]  = mkv(0, 7'd0, 8'd0, 1, C,  0, 7'd0, 6'b110000, '0, '0);
    tv[6]  = mkv(0, 7'd0, 8'd0, 0, '0, 0, 7'd0, 6'b001100, '0, '0);
    tv[7]  = mkv(0, 7'd0, 8'd0, 0, '0, 1, 7'd5, 6'b000100, '0, '0);
    tv[8]  = mkv(0, 7'd0, 8'd0, 0, '0, 1, 7'd6, 6'b000101, '0, A);
    tv[9]  = mkv(0, 7'd0, 8'd0, 0, '0, 1, 7'd7, 6'b000101, '0, B);
    tv[10] = mkv(0, 7'd0, 8'd0, 0, '0, 0, 7'd0, 6'b000111, A,  C);
    tv[11] = mkv(0, 7'd0, 8'd0, 0, '0, 0, 7'd0, 6'b000110, B,  '0);
    tv[12] = mkv(0, 7'd0, 8'd0, 0, '0, 0, 7'd0, 6'b000110, C,  '0);
    tv[13] = mkv(0, 7'd0, 8'd0, 0, '0, 0, 7'd0, 6'b000100, '0, '0);

    // reset then idle
    rst_n = 0; idle_in();
    step(); step();
    @(negedge clk);
    chk("rst_flags", {lr, busy, done, rr, v2, v0}, 6'b000100);
    chk("rst_data_lat2", d2, '0);
    chk("rst_data_lat0", d0, '0);
    rst_n = 1;
    step();

    // zero-length command is ignored
    st = 1; base = 7'd3; len = 8'd0;
    @(negedge clk); step();
    st = 0;
    @(negedge clk);
    chk("len0_ignored", {lr, busy, rr}, 3'b001);
    step();

    // burst base=5 len=3 with gaps, then read back through both latencies
    for (int i = 0; i < 14; i++) begin
      st = tv[i].st; base = tv[i].base; len = tv[i].len; lv = tv[i].lv;
      dat = tv[i].dat; msk = 4'hF; rq = tv[i].rq; ra = tv[i].ra;
      @(negedge clk);
      chk($sformatf("vec%0d_flags", i), {lr, busy, done, rr, v2, v0}, tv[i].ef);
      if (tv[i].ef[1]) chk($sformatf("vec%0d_d2", i), d2, tv[i].ed2);
      if (tv[i].ef[0]) chk($sformatf("vec%0d_d0", i), d0, tv[i].ed0);
      step();
    end
    idle_in();

    // wrap past the top, then a masked overwrite
    for (int i = 0; i < 6; i++) begin
      bd[i] = mkw(8'h10 * 8'(i + 1)); bm[i] = 4'hF;
    end
    burst(7'd126, 8'd6);
    bd[0] = mkw(8'hF0); bm[0] = 4'b0101;
    bd[1] = mkw(8'h70); bd[2] = mkw(8'h80); bd[3] = mkw(8'h90);
    bm[1] = 4'hF; bm[2] = 4'hF; bm[3] = 4'hF;
    burst(7'd126, 8'd4);
    rd_chk("mask_126", 7'd126, 128'h13131313_F2F2F2F2_11111111_F0F0F0F0);
    rd_chk("wrap_127", 7'd127, mkw(8'h70));
    rd_chk("wrap_0",   7'd0,   mkw(8'h80));
    rd_chk("wrap_1",   7'd1,   mkw(8'h90));

    // four back-to-back reads
    exp4[0] = mkw(8'h80); exp4[1] = mkw(8'h90); exp4[2] = mkw(8'h50); exp4[3] = mkw(8'h60);
    for (int k = 0; k < 8; k++) begin
      rq = (k < 4); ra = 7'(k);
      @(negedge clk);
      chk($sformatf("pipe%0d_v2", k), v2, (k >= 3 && k < 7));
      if (k >= 3 && k < 7) chk($sformatf("pipe%0d_d2", k), d2, exp4[k-3]);
      chk($sformatf("pipe%0d_v0", k), v0, (k >= 1 && k < 5));
      if (k >= 1 && k < 5) chk($sformatf("pipe%0d_d0", k), d0, exp4[k-1]);
      step();
    end
    idle_in();

    // read accepted alongside ld_start still returns pre-load data
    rq = 1; ra = 7'd6;
    @(negedge clk); step();
    ra = 7'd5; st = 1; base = 7'd5; len = 8'd1;
    @(negedge clk);
    chk("il_rr_idle", rr, 1'b1);
    chk("il_lat0_B", {v0, d0}, {1'b1, B});
    step();
    st = 0; lv = 1; dat = Z;
    @(negedge clk);
    chk("il_rr_load", rr, 1'b0);
    chk("il_lat0_A", {v0, d0}, {1'b1, A});
    step();
    lv = 0; rq = 0;
    @(negedge clk);
    chk("il_lat2_B", {v2, d2}, {1'b1, B});
    chk("il_done", done, 1'b1);
    chk("il_lat0_drop", v0, 1'b0);
    step();
    @(negedge clk);
    chk("il_old_data", {v2, d2}, {1'b1, A});
    step();
    @(negedge clk);
    chk("il_load_rd_dropped", v2, 1'b0);
    chk("rd_data_hold", d2, A);
    step();
    rd_chk("il_new_data", 7'd5, Z);

    // reset after 2 of 5 beats
    st = 1; base = 7'd20; len = 8'd5;
    @(negedge clk); step();
    st = 0; lv = 1; dat = mkw(8'h31);
    step();
    dat = mkw(8'h41);
    step();
    lv = 0; rst_n = 0;
    @(negedge clk); step();
    rst_n = 1;
    @(negedge clk);
    chk("mr_idle", {lr, busy, done, rr}, 4'b0001);
    step();
    @(negedge clk);
    chk("mr_no_done", done, 1'b0);
    step();
    rd_chk("mr_beat0", 7'd20, mkw(8'h31));
    rd_chk("mr_beat1", 7'd21, mkw(8'h41));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
